// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker
//
// Receive-side monitor for a one-hot ring counter bus. Each accepted sample is
// decoded to a binary position, and consecutive legal samples are expected to
// advance by exactly one position, with position WIDTH-1 wrapping to 0. The
// block acquires lock after LOCK_COUNT correct advances. Once locked, any
// break in the sequence or any illegal word raises a one-cycle seq_err pulse
// and bumps a saturating error counter.
//
// Parameters:
//   WIDTH      ring length in bits (2..16)
//   IDX_W      width of the decoded index
//   LOCK_COUNT consecutive correct advances needed to lock (>= 1)
//   ERR_CNT_W  width of the saturating error counter
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   q_in       monitored ring word, bit 0 = position 0
//   valid_in   q_in is sampled only when this is high
//   index      position of the last legal sample
//   onehot_ok  last accepted sample had exactly one bit set
//   locked     sequence tracking established
//   seq_err    one-cycle pulse on a broken sequence or illegal word while locked
//   err_count  number of seq_err pulses, saturating at all-ones
//
// All outputs are registered and reflect a sample on the edge that accepts it.

module ring_sequence_checker #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned IDX_W      = $clog2(WIDTH),
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     q_in,
    input  logic                 valid_in,
    output logic [IDX_W-1:0]     index,
    output logic                 onehot_ok,
    output logic                 locked,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Bits needed to count set bits of q_in, and to count matches up to LOCK_COUNT.
    localparam int unsigned CntW   = $clog2(WIDTH + 1);
    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);

    localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(WIDTH - 1);
    localparam logic [MatchW-1:0] LockCnt  = MatchW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   onehot_ok_q, onehot_ok_d;
    logic                   seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic [MatchW-1:0]      match_q, match_d;

    // Decoder outputs
    logic [CntW-1:0]        ones_cnt;
    logic [IDX_W-1:0]       sample_pos;
    logic                   sample_legal;

    // Sequence comparison
    logic [IDX_W-1:0]       exp_idx;
    logic                   is_next;
    logic [MatchW-1:0]      match_inc;

    // ------------------------------------------------------------------------
    // One-hot decode: count set bits and remember the position of the set bit.
    // For a legal word only one bit is set, so the last hit is the only hit.
    // ------------------------------------------------------------------------
    always_comb begin
        ones_cnt   = '0;
        sample_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_in[i]) begin
                ones_cnt   = ones_cnt + CntW'(1);
                sample_pos = IDX_W'(i);
            end
        end
        sample_legal = (ones_cnt == CntW'(1));
    end

    // ------------------------------------------------------------------------
    // Expected next position. index_q always holds the last legal index, which
    // is the reference for the sequence check in every tracking state.
    // ------------------------------------------------------------------------
    always_comb begin
        exp_idx   = (index_q == LastIdx) ? '0 : index_q + IDX_W'(1);
        is_next   = (sample_pos == exp_idx);
        match_inc = match_q + MatchW'(1);
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        onehot_ok_d = onehot_ok_q;
        match_d     = match_q;
        seq_err_d   = 1'b0;
        err_count_d = err_count_q;

        if (valid_in) begin
            onehot_ok_d = sample_legal;
            // Illegal words leave the index (and so the reference) untouched.
            if (sample_legal) begin
                index_d = sample_pos;
            end

            unique case (state_q)
                StUnlocked: begin
                    if (sample_legal) begin
                        state_d = StAcquire;
                        match_d = '0;
                    end
                end

                StAcquire: begin
                    if (!sample_legal) begin
                        state_d = StUnlocked;
                        match_d = '0;
                    end else if (is_next) begin
                        match_d = match_inc;
                        if (match_inc == LockCnt) begin
                            state_d = StLocked;
                        end
                    end else begin
                        // Re-seed on the new index; the count starts over.
                        match_d = '0;
                    end
                end

                StLocked: begin
                    if (!sample_legal) begin
                        seq_err_d = 1'b1;
                        state_d   = StUnlocked;
                        match_d   = '0;
                    end else if (!is_next) begin
                        // Covers skips, backward steps and a stalled ring.
                        seq_err_d = 1'b1;
                        state_d   = StAcquire;
                        match_d   = '0;
                    end
                end

                default: begin
                    state_d = StUnlocked;
                    match_d = '0;
                end
            endcase

            if (seq_err_d && (err_count_q != '1)) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StUnlocked;
            index_q     <= '0;
            onehot_ok_q <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
            match_q     <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            onehot_ok_q <= onehot_ok_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
            match_q     <= match_d;
        end
    end

    assign index     = index_q;
    assign onehot_ok = onehot_ok_q;
    assign locked    = (state_q == StLocked);
    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker. Two instances share one stimulus stream:
// one with the default 8-bit error counter and one with a 2-bit counter so
// that saturation is exercised. Directed sequences come first, then random
// traffic, all compared against a behavioural model of the sequence rules.

module tb_ring_sequence_checker;

    localparam int unsigned W  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned LC = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [W-1:0]  q_in;

    logic [IW-1:0] index_a,     index_b;
    logic          onehot_ok_a, onehot_ok_b;
    logic          locked_a,    locked_b;
    logic          seq_err_a,   seq_err_b;
    logic [7:0]    err_count_a;
    logic [1:0]    err_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_ref;      // last legal position
    int m_run;      // consecutive +1 advances since the last seed
    bit m_have;     // a reference position is being tracked
    bit m_locked;
    bit m_ok;
    bit m_err;
    int m_errs;     // total seq_err pulses since reset, unbounded

    always #5 clock = ~clock;

    ring_sequence_checker #(
        .WIDTH     (W),
        .LOCK_COUNT(LC),
        .ERR_CNT_W (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .q_in     (q_in),
        .valid_in (valid_in),
        .index    (index_a),
        .onehot_ok(onehot_ok_a),
        .locked   (locked_a),
        .seq_err  (seq_err_a),
        .err_count(err_count_a)
    );

    ring_sequence_checker #(
        .WIDTH     (W),
        .LOCK_COUNT(LC),
        .ERR_CNT_W (2)
    ) dut_sat (
        .clock    (clock),
        .reset    (reset),
        .q_in     (q_in),
        .valid_in (valid_in),
        .index    (index_b),
        .onehot_ok(onehot_ok_b),
        .locked   (locked_b),
        .seq_err  (seq_err_b),
        .err_count(err_count_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [W-1:0] q);
        int pos;
        m_err = 0;
        if (r) begin
            m_ref = 0; m_run = 0; m_have = 0; m_locked = 0; m_ok = 0; m_errs = 0;
        end else if (v) begin
            if ($countones(q) == 1) begin
                pos = 0;
                for (int i = 0; i < W; i++) if (q[i]) pos = i;
                m_ok = 1;
                if (!m_have) begin
                    m_have = 1;
                    m_run  = 0;
                end else if (pos == (m_ref + 1) % W) begin
                    m_run++;
                    if (m_run >= LC) m_locked = 1;
                end else begin
                    if (m_locked) begin m_err = 1; m_errs++; end
                    m_locked = 0;
                    m_run    = 0;
                end
                m_ref = pos;
            end else begin
                m_ok = 0;
                if (m_locked) begin m_err = 1; m_errs++; end
                m_locked = 0;
                m_have   = 0;
            end
        end
    endtask

    task automatic compare_all();
        int sat_a, sat_b;
        sat_a = (m_errs > 255) ? 255 : m_errs;
        sat_b = (m_errs > 3) ? 3 : m_errs;
        check_eq("index",       32'(index_a),     32'(m_ref));
        check_eq("onehot_ok",   32'(onehot_ok_a), 32'(m_ok));
        check_eq("locked",      32'(locked_a),    32'(m_locked));
        check_eq("seq_err",     32'(seq_err_a),   32'(m_err));
        check_eq("err_count",   32'(err_count_a), 32'(sat_a));
        check_eq("sat_index",   32'(index_b),     32'(m_ref));
        check_eq("sat_locked",  32'(locked_b),    32'(m_locked));
        check_eq("sat_seq_err", 32'(seq_err_b),   32'(m_err));
        check_eq("sat_err_cnt", 32'(err_count_b), 32'(sat_b));
    endtask

    // Drive one cycle: inputs set on the falling edge, outputs checked 1 time
    // unit after the rising edge that samples them.
    task automatic cycle(input bit r, input bit v, input logic [W-1:0] q);
        @(negedge clock);
        reset    = r;
        valid_in = v;
        q_in     = q;
        @(posedge clock);
        model_step(r, v, q);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [W-1:0] q);
        cycle(1'b0, 1'b1, q);
    endtask

    logic [1:0] sat_exp [5];

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] last_word;
        int sel;

        reset    = 1'b1;
        valid_in = 1'b0;
        q_in     = '0;
        sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset then rotation
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        check_eq("t1_rst_locked", 32'(locked_a), 0);
        check_eq("t1_rst_index",  32'(index_a),  0);
        send(4'b0001);
        send(4'b0010);
        check_eq("t1_not_yet_locked", 32'(locked_a), 0);
        send(4'b0100);
        check_eq("t1_locked", 32'(locked_a), 1);
        send(4'b1000);
        send(4'b0001);
        check_eq("t1_wrap_index", 32'(index_a), 0);

        // Wrap and idle gaps with junk on the bus
        send(4'b0010);
        send(4'b0100);
        send(4'b1000);
        for (int i = 0; i < 5; i++) cycle(0, 0, 4'b0110);
        check_eq("t2_gap_locked", 32'(locked_a), 1);
        check_eq("t2_gap_index",  32'(index_a),  3);
        send(4'b0001);
        check_eq("t2_after_gap_index", 32'(index_a), 0);

        // Skip error at index 1, then relock
        send(4'b0010);
        send(4'b1000);
        check_eq("t3_seq_err",   32'(seq_err_a),   1);
        check_eq("t3_err_count", 32'(err_count_a), 1);
        check_eq("t3_index",     32'(index_a),     3);
        send(4'b0001);
        check_eq("t3_pulse_once", 32'(seq_err_a), 0);
        send(4'b0010);
        check_eq("t3_relock", 32'(locked_a), 1);

        // Illegal words
        send(4'b0100);
        send(4'b0000);
        check_eq("t4_onehot_ok", 32'(onehot_ok_a), 0);
        check_eq("t4_seq_err",   32'(seq_err_a),   1);
        check_eq("t4_index",     32'(index_a),     2);
        send(4'b0011);
        check_eq("t4_no_err_unlocked", 32'(seq_err_a), 0);
        check_eq("t4_unlocked",        32'(locked_a),  0);

        // Saturation of the 2-bit counter over five locked skips
        cycle(1, 0, '0);
        send(4'b0001);
        send(4'b0010);
        send(4'b0100);
        for (int k = 0; k < 5; k++) begin
            send(4'b0001);
            check_eq("t5_sat_count", 32'(err_count_b), 32'(sat_exp[k]));
            check_eq("t5_sat_pulse", 32'(seq_err_b), 1);
            send(4'b0010);
            send(4'b0100);
        end
        check_eq("t5_wide_count", 32'(err_count_a), 5);

        // Reset mid-lock with errors recorded
        cycle(1, 0, '0);
        send(4'b0001); send(4'b0010); send(4'b0100);
        send(4'b0001); send(4'b0010); send(4'b0100);
        send(4'b0001); send(4'b0010); send(4'b0100);
        check_eq("t6_pre_count",  32'(err_count_a), 2);
        check_eq("t6_pre_locked", 32'(locked_a),    1);
        cycle(1, 1, 4'b1000);
        check_eq("t6_rst_count",  32'(err_count_a), 0);
        check_eq("t6_rst_locked", 32'(locked_a),    0);
        check_eq("t6_rst_ok",     32'(onehot_ok_a), 0);
        send(4'b0100);
        send(4'b1000);
        send(4'b0001);
        check_eq("t6_relock", 32'(locked_a), 1);

        // Random traffic
        last_word = 4'b0001;
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                word = '0;
                word[(m_ref + 1) % W] = 1'b1;
            end else if (sel < 8) begin
                word = '0;
                word[$urandom_range(0, W - 1)] = 1'b1;
            end else if (sel == 8) begin
                word = W'($urandom_range(0, (1 << W) - 1));
            end else begin
                word = last_word;
            end
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, word);
            last_word = word;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
